// File: rtl/ddr_local_req_bridge_pkg.sv
// Shared constants and FSM encoding for the DDR local-interface request bridge.
package ddr_local_pkg;

    localparam int DEF_ADDR_W   = 26;
    localparam int DEF_DATA_W   = 128;
    localparam int DEF_BE_W     = 16;
    localparam int DEF_RD_DEPTH = 8;

    localparam logic [2:0] LOCAL_SIZE_ONE = 3'd1;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2
    } fsm_e;

endpackage

// File: rtl/ddr_local_req_bridge_if.sv
// Upstream command/response channels of the bridge.
// Both channels are valid/ready: a beat transfers on the rising edge where valid and ready are both 1.
interface ddr_local_req_bridge_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 128,
    parameter int BE_W   = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ddr_local_req_bridge_rd_fifo.sv
// Show-ahead synchronous FIFO (flop array) buffering read data returned by the controller.
module ddr_rd_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_push  = i_push && (!w_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/ddr_local_req_bridge.sv
// Front-end turning single-beat commands into local_*_req strobes, with credit-protected read return.
// Optional build macro DDR_LOCAL_BRIDGE_PERF_EN adds saturating perf_rd/wr/stall counters.
module ddr_local_req_bridge
    import ddr_local_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic                      phy_clk,
    input  logic                      reset_phy_clk_n,
    ddr_local_req_bridge_if.slave     bus,
    output logic [ADDR_W-1:0]         local_address,
    output logic                      local_write_req,
    output logic                      local_read_req,
    output logic                      local_burstbegin,
    output logic [DATA_W-1:0]         local_wdata,
    output logic [BE_W-1:0]           local_be,
    output logic [2:0]                local_size,
    input  logic                      local_ready,
    input  logic [DATA_W-1:0]         local_rdata,
    input  logic                      local_rdata_valid,
    input  logic                      local_init_done,
    output logic [$clog2(RD_DEPTH):0] rd_outstanding,
    output logic [1:0]                dbg_state
`ifdef DDR_LOCAL_BRIDGE_PERF_EN
    ,
    output logic [31:0]               perf_rd_cnt,
    output logic [31:0]               perf_wr_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);
    localparam int CW = $clog2(RD_DEPTH) + 1;
    localparam logic [1:0] S_WAIT_INIT = WAIT_INIT;
    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_ISSUE     = ISSUE;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_wr_req;
    logic              r_rd_req;
    logic              r_bb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [CW-1:0]     r_credits;
    logic              w_cmd_hs;
    logic              w_rd_hs;
    logic              w_rsp_hs;
    logic              w_accept;
    logic              w_fifo_empty;
    logic              w_push;

    assign bus.cmd_ready = (r_state == S_IDLE) && local_init_done &&
                           (bus.cmd_write || (r_credits != '0));
    assign w_cmd_hs = bus.cmd_valid && bus.cmd_ready;
    assign w_rd_hs  = w_cmd_hs && !bus.cmd_write;
    assign w_rsp_hs = bus.rsp_valid && bus.rsp_ready;
    assign w_accept = (r_wr_req || r_rd_req) && local_ready;

    assign local_address    = r_addr;
    assign local_write_req  = r_wr_req;
    assign local_read_req   = r_rd_req;
    assign local_burstbegin = r_bb;
    assign local_wdata      = r_wdata;
    assign local_be         = r_be;
    assign local_size       = LOCAL_SIZE_ONE;
    assign rd_outstanding   = CW'(RD_DEPTH) - r_credits;
    assign dbg_state        = r_state;

    // A held request always completes before falling back to WAIT_INIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_INIT: if (local_init_done) w_next = S_IDLE;
            S_IDLE: begin
                if (!local_init_done) w_next = S_WAIT_INIT;
                else if (w_cmd_hs)    w_next = S_ISSUE;
            end
            S_ISSUE: if (local_ready) w_next = local_init_done ? S_IDLE : S_WAIT_INIT;
            default: w_next = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            r_state  <= S_WAIT_INIT;
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_bb     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
        end else begin
            r_state <= w_next;
            if (w_cmd_hs) begin
                r_wr_req <= bus.cmd_write;
                r_rd_req <= !bus.cmd_write;
                r_bb     <= 1'b1;
                r_addr   <= bus.cmd_addr;
                r_wdata  <= bus.cmd_wdata;
                r_be     <= bus.cmd_be;
            end else begin
                r_bb <= 1'b0;
                if (local_ready) begin
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b0;
                end
            end
        end
    end

    // Credits are taken at command acceptance so the FIFO can absorb every unstallable return.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            r_credits <= CW'(RD_DEPTH);
        end else begin
            case ({w_rd_hs, w_rsp_hs})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign w_push = local_rdata_valid && (r_credits != CW'(RD_DEPTH));

    ddr_rd_fifo #(
        .W     (DATA_W),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clk     (phy_clk),
        .rst_n   (reset_phy_clk_n),
        .i_push  (w_push),
        .i_wdata (local_rdata),
        .i_pop   (w_rsp_hs),
        .o_rdata (bus.rsp_rdata),
        .o_empty (w_fifo_empty)
    );

    assign bus.rsp_valid = !w_fifo_empty;

    a_no_stray_rdata: assert property (@(posedge phy_clk) disable iff (!reset_phy_clk_n)
        !(local_rdata_valid && (r_credits == CW'(RD_DEPTH))));

`ifdef DDR_LOCAL_BRIDGE_PERF_EN
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_accept && r_rd_req && (perf_rd_cnt != '1)) perf_rd_cnt <= perf_rd_cnt + 32'd1;
            if (w_accept && r_wr_req && (perf_wr_cnt != '1)) perf_wr_cnt <= perf_wr_cnt + 32'd1;
            if ((r_state == S_ISSUE) && !local_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ddr_local_req_bridge.sv
// Directed self-checking bench for ddr_local_req_bridge (honours DDR_LOCAL_BRIDGE_PERF_EN).
module tb_ddr_local_req_bridge;
    localparam int AW = 26;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int CW = 4;

    // clock / reset
    logic phy_clk = 1'b0;
    logic reset_phy_clk_n = 1'b0;
    always #5 phy_clk = ~phy_clk;

    ddr_local_req_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

    logic [AW-1:0] local_address;
    logic          local_write_req;
    logic          local_read_req;
    logic          local_burstbegin;
    logic [DW-1:0] local_wdata;
    logic [BW-1:0] local_be;
    logic [2:0]    local_size;
    logic          local_ready = 1'b0;
    logic [DW-1:0] local_rdata = '0;
    logic          local_rdata_valid = 1'b0;
    logic          local_init_done = 1'b0;
    logic [CW-1:0] rd_outstanding;
    logic [1:0]    dbg_state;
`ifdef DDR_LOCAL_BRIDGE_PERF_EN
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    ddr_local_req_bridge dut (
        .phy_clk           (phy_clk),
        .reset_phy_clk_n   (reset_phy_clk_n),
        .bus               (bus),
        .local_address     (local_address),
        .local_write_req   (local_write_req),
        .local_read_req    (local_read_req),
        .local_burstbegin  (local_burstbegin),
        .local_wdata       (local_wdata),
        .local_be          (local_be),
        .local_size        (local_size),
        .local_ready       (local_ready),
        .local_rdata       (local_rdata),
        .local_rdata_valid (local_rdata_valid),
        .local_init_done   (local_init_done),
        .rd_outstanding    (rd_outstanding),
        .dbg_state         (dbg_state)
`ifdef DDR_LOCAL_BRIDGE_PERF_EN
        ,
        .perf_rd_cnt       (perf_rd_cnt),
        .perf_wr_cnt       (perf_wr_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int acc_wr = 0;
    int acc_rd = 0;
    int n_bb = 0;
    bit tgl_en = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge phy_clk) begin
        if (local_write_req && local_ready) acc_wr++;
        if (local_read_req && local_ready)  acc_rd++;
        if (local_burstbegin)               n_bb++;
    end

    initial forever begin
        @(negedge phy_clk);
        if (tgl_en) local_ready = ~local_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // driver tasks
    task automatic send_cmd(input string tag, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] be);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_be    = be;
        #1;
        while (!bus.cmd_ready && n < 40) begin
            @(negedge phy_clk);
            #1;
            n++;
        end
        check({tag, "_accept"}, bus.cmd_ready, 1);
        @(negedge phy_clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_beats(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            local_rdata       = base + DW'(i);
            local_rdata_valid = 1'b1;
            exp_q.push_back(base + DW'(i));
            @(negedge phy_clk);
        end
        local_rdata_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, bus.rsp_valid, 1);
        check({tag, "_data"}, bus.rsp_rdata, e);
        bus.rsp_ready = 1'b1;
        @(negedge phy_clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int base_wr;
        int base_rd;
        int base_bb;
        int n;
        logic [DW-1:0] e;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_be    = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge phy_clk);
        check("rst_reqs", {local_write_req, local_read_req, local_burstbegin}, 0);
        check("rst_size", local_size, 1);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_outstanding", rd_outstanding, 0);
        check("rst_addr", local_address, 0);
        check("rst_state", dbg_state, 0);
        reset_phy_clk_n = 1'b1;
        bus.cmd_write = 1'b1;

        // calibration wait
        repeat (20) @(negedge phy_clk);
        check("init_cmd_ready", bus.cmd_ready, 0);
        check("init_reqs", {local_write_req, local_read_req}, 0);
        local_init_done = 1'b1;
        @(negedge phy_clk);
        check("init_done_ready", bus.cmd_ready, 1);
        check("init_done_state", dbg_state, 1);

        // write held for 3 stall cycles
        local_ready = 1'b0;
        send_cmd("wr", 1'b1, 26'h0000123, {16{8'hA5}}, 16'hFFFF);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wr_req_c%0d", c), local_write_req, 1);
            check($sformatf("wr_bb_c%0d", c), local_burstbegin, (c == 1));
            check($sformatf("wr_addr_c%0d", c), local_address, 26'h0000123);
            check($sformatf("wr_data_c%0d", c), local_wdata, {16{8'hA5}});
            check($sformatf("wr_be_c%0d", c), local_be, 16'hFFFF);
            check($sformatf("wr_rdreq_c%0d", c), local_read_req, 0);
            check($sformatf("wr_cmd_ready_c%0d", c), bus.cmd_ready, 0);
            if (c == 4) local_ready = 1'b1;
            @(negedge phy_clk);
        end
        check("wr_req_drop", local_write_req, 0);
        check("wr_state_idle", dbg_state, 1);
`ifdef DDR_LOCAL_BRIDGE_PERF_EN
        check("perf_stall", perf_stall_cnt, 3);
        check("perf_wr", perf_wr_cnt, 1);
        check("perf_rd", perf_rd_cnt, 0);
`endif

        // credit exhaustion
        for (int i = 0; i < 8; i++) send_cmd($sformatf("rd%0d", i), 1'b0, AW'(i), '0, '0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 26'd8;
        @(negedge phy_clk);
        check("rd9_stall_a", bus.cmd_ready, 0);
        check("rd9_outst", rd_outstanding, 8);
        @(negedge phy_clk);
        check("rd9_stall_b", bus.cmd_ready, 0);
        push_beats(128'd0, 8);
        check("rd9_stall_c", bus.cmd_ready, 0);
        pop_check("rsp0");
        check("rd9_ready", bus.cmd_ready, 1);
        @(negedge phy_clk);
        bus.cmd_valid = 1'b0;
        check("rd9_outst_after", rd_outstanding, 8);
        for (int i = 1; i < 8; i++) pop_check($sformatf("rsp%0d", i));
        push_beats(128'd8, 1);
        pop_check("rsp8");
        check("rd_drain_outst", rd_outstanding, 0);
        check("rd_drain_valid", bus.rsp_valid, 0);

        // interleaved traffic with toggling local_ready
        base_wr = acc_wr;
        base_rd = acc_rd;
        base_bb = n_bb;
        tgl_en = 1'b1;
        for (int i = 0; i < 6; i++)
            send_cmd($sformatf("il%0d", i), (i % 2 == 0), AW'(26'h200 + i), DW'(128'h5000 + i), 16'h00FF);
        n = 0;
        while (dbg_state != 2'd1 && n < 20) begin
            @(negedge phy_clk);
            n++;
        end
        check("il_settle", dbg_state, 1);
        tgl_en = 1'b0;
        local_ready = 1'b1;
        check("il_wr_count", acc_wr - base_wr, 3);
        check("il_rd_count", acc_rd - base_rd, 3);
        check("il_bb_count", n_bb - base_bb, 6);
        check("il_outst", rd_outstanding, 3);
        push_beats(128'hA0, 3);
        for (int i = 0; i < 3; i++) pop_check($sformatf("il_rsp%0d", i));
        check("il_outst_done", rd_outstanding, 0);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) send_cmd($sformatf("fr%0d", i), 1'b0, AW'(26'h300 + i), '0, '0);
        @(negedge phy_clk);
        push_beats(128'h100, 8);
        check("full_outst", rd_outstanding, 8);
        e = exp_q.pop_front();
        check("full_head", bus.rsp_rdata, e);
        local_rdata       = 128'h1FF;
        local_rdata_valid = 1'b1;
        bus.rsp_ready     = 1'b1;
        exp_q.push_back(128'h1FF);
        @(negedge phy_clk);
        local_rdata_valid = 1'b0;
        bus.rsp_ready     = 1'b0;
        check("full_outst_after", rd_outstanding, 7);
        for (int i = 1; i < 8; i++) pop_check($sformatf("full_rsp%0d", i));
        check("full_outst_drain", rd_outstanding, 0);
        check("full_tail_valid", bus.rsp_valid, 1);
        check("full_tail_data", bus.rsp_rdata, exp_q[0]);

        // asynchronous reset in the middle of ISSUE
        local_ready = 1'b0;
        send_cmd("rst_rd", 1'b0, 26'h3FF, '0, '0);
        repeat (3) @(negedge phy_clk);
        check("pre_rst_req", local_read_req, 1);
        check("pre_rst_outst", rd_outstanding, 1);
        #2;
        reset_phy_clk_n = 1'b0;
        #1;
        check("arst_req", local_read_req, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_outst", rd_outstanding, 0);
        check("arst_state", dbg_state, 0);
`ifdef DDR_LOCAL_BRIDGE_PERF_EN
        check("arst_perf", {perf_rd_cnt, perf_wr_cnt, perf_stall_cnt}, 0);
`endif
        @(negedge phy_clk);
        reset_phy_clk_n = 1'b1;
        repeat (2) @(negedge phy_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
